pattern_burst_ctrl: RTL and testbench

PATTERN_BURST_CTRL -- requirements
Module: pattern_burst_ctrl

---
 rtl/pattern_burst_ctrl.sv | 154 +++++++++++++++
 tb/tb_pattern_burst_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_burst_ctrl.sv
// Pattern burst generator: emits NUM_BURST bursts of pattern words with valid/ready handshaking.
// Define PATTERN_BURST_CTRL_LFSR_EN to make mode 3 a PRBS8 sequence; otherwise mode 3 counts up.
module pattern_burst_ctrl #(
  parameter int unsigned NUM_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_burst_len,
  input  logic [7:0] i_gap_len,
  input  logic [7:0] i_seed,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  localparam logic [7:0] LastBurst = 8'(NUM_BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] len_q, len_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] data_q, data_d;
  logic [8:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

  logic [8:0] burst_words;
  logic       start, xfer, last_beat, last_burst, gap_end;

  function automatic logic [7:0] first_word(input logic [1:0] mode, input logic [7:0] seed);
    case (mode)
      2'd1:    first_word = 8'h01;
`ifdef PATTERN_BURST_CTRL_LFSR_EN
      2'd3:    first_word = (seed == 8'h00) ? 8'h01 : seed;
`endif
      default: first_word = seed;
    endcase
  endfunction

  function automatic logic [7:0] next_word(input logic [1:0] mode, input logic [7:0] d);
    case (mode)
      2'd1:    next_word = {d[6:0], d[7]};
      2'd2:    next_word = d;
`ifdef PATTERN_BURST_CTRL_LFSR_EN
      2'd3:    next_word = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`endif
      default: next_word = d + 8'd1;
    endcase
  endfunction

  // Abort outranks everything, including a start seen in the same cycle.
  assign start       = (state_q == StIdle) & i_start & ~i_abort;
  assign xfer        = (state_q == StSend) & i_ready;
  assign burst_words = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign last_beat   = (beat_cnt_q == burst_words - 9'd1);
  assign last_burst  = (burst_cnt_q == LastBurst);
  assign gap_end     = (gap_cnt_q == 8'd0);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StSend;
      StSend: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (xfer && last_beat) begin
          if (last_burst)          state_d = StDone;
          else if (gap_q != 8'd0)  state_d = StGap;
          else                     state_d = StSend;
        end
      end
      StGap: begin
        if (i_abort)      state_d = StIdle;
        else if (gap_end) state_d = StSend;
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_data  = data_q;
    o_valid = (state_q == StSend);
    o_busy  = (state_q != StIdle);
    o_done  = (state_q == StDone);
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      mode_q      <= 2'd0;
      len_q       <= 8'd0;
      gap_q       <= 8'd0;
      data_q      <= 8'd0;
      beat_cnt_q  <= 9'd0;
      burst_cnt_q <= 8'd0;
      gap_cnt_q   <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      data_q      <= data_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    len_d       = len_q;
    gap_d       = gap_q;
    data_d      = data_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (start) begin
      mode_d      = i_mode;
      len_d       = i_burst_len;
      gap_d       = i_gap_len;
      data_d      = first_word(i_mode, i_seed);
      beat_cnt_d  = 9'd0;
      burst_cnt_d = 8'd0;
      gap_cnt_d   = 8'd0;
    end else if (!i_abort) begin
      if (xfer) begin
        // Pattern runs on across burst boundaries.
        data_d = next_word(mode_q, data_q);
        if (last_beat) begin
          beat_cnt_d  = 9'd0;
          burst_cnt_d = burst_cnt_q + 8'd1;
          gap_cnt_d   = gap_q - 8'd1;
        end else begin
          beat_cnt_d = beat_cnt_q + 9'd1;
        end
      end
      if (state_q == StGap && !gap_end) gap_cnt_d = gap_cnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_pattern_burst_ctrl.sv
// Self-checking bench for pattern_burst_ctrl: directed scenarios plus randomized runs with
// random backpressure, checked cycle by cycle against a word-index based reference model.
module tb_pattern_burst_ctrl;

  localparam int NB = 2;

  logic       clk;
  logic       res_n;
  logic       i_start, i_abort, i_ready;
  logic [1:0] i_mode;
  logic [7:0] i_burst_len, i_gap_len, i_seed;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  pattern_burst_ctrl #(.NUM_BURST(NB)) dut (
    .i_clk      (clk),
    .i_res_n    (res_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_mode     (i_mode),
    .i_burst_len(i_burst_len),
    .i_gap_len  (i_gap_len),
    .i_seed     (i_seed),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k-th word of a run, counted from the first word after start.
  function automatic logic [7:0] exp_word(input logic [1:0] mode, input logic [7:0] seed,
                                          input int k);
    case (mode)
      2'd1: return 8'(1 << (k % 8));
      2'd2: return seed;
      2'd3: begin
`ifdef PATTERN_BURST_CTRL_LFSR_EN
        logic [7:0] d;
        d = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < k; i++) d = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
        return d;
`else
        return seed + 8'(k);
`endif
      end
      default: return seed + 8'(k);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: valid/busy/done got %b%b%b expected 000", name, o_valid, o_busy,
               o_done);
    end
  endtask

  // ready_pct < 0 selects strict 1/0 toggling of i_ready.
  task automatic run_check(input logic [1:0] mode, input logic [7:0] seed, input logic [7:0] len,
                           input logic [7:0] gap, input int ready_pct, input string name);
    int words, total, idx, gap_left, cyc, ph;
    logic [7:0] exp_d;
    logic rdy;
    bit fin;
    words = (len == 8'd0) ? 256 : int'(len);
    total = NB * words;
    i_mode = mode; i_seed = seed; i_burst_len = len; i_gap_len = gap; i_start = 1'b1;
    tick();
    // Scramble config to prove it was latched.
    i_start = 1'b0;
    i_mode = 2'($urandom); i_seed = 8'($urandom);
    i_burst_len = 8'($urandom); i_gap_len = 8'($urandom);
    idx = 0; gap_left = 0; cyc = 0; ph = 0; fin = 0;
    while (!fin) begin
      rdy = (ready_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < ready_pct);
      i_ready = rdy;
      i_start = (ph < 3) ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      case (ph)
        0: begin
          checks++;
          if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s send word %0d: valid/busy/done got %b%b%b expected 110", name, idx,
                     o_valid, o_busy, o_done);
          end
          exp_d = exp_word(mode, seed, idx);
          checks++;
          if (o_data !== exp_d) begin
            errors++;
            $display("FAIL %s data word %0d: got %02h expected %02h", name, idx, o_data, exp_d);
          end
          if (rdy) begin
            idx++;
            if (idx == total) ph = 2;
            else if (idx % words == 0 && gap != 8'd0) begin
              ph = 1;
              gap_left = int'(gap);
            end
          end
        end
        1: begin
          checks++;
          if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s gap: valid/busy/done got %b%b%b expected 010", name, o_valid,
                     o_busy, o_done);
          end
          gap_left--;
          if (gap_left == 0) ph = 0;
        end
        2: begin
          checks++;
          if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: valid/busy/done got %b%b%b expected 011", name, o_valid,
                     o_busy, o_done);
          end
          ph = 3;
        end
        default: begin
          check_idle({name, "_end"});
          fin = 1;
        end
      endcase
      cyc++;
      if (!fin && cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: got %0d of %0d transfers", name, idx, total);
        fin = 1;
      end
      tick();
    end
    i_start = 1'b0;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset data: got %02h expected 00", o_data);
    end
    check_idle("reset");
    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_reset_no_start");
    end
  endtask

  task automatic test_abort();
    i_mode = 2'd0; i_seed = 8'h30; i_burst_len = 8'd4; i_gap_len = 8'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h30) begin
      errors++;
      $display("FAIL abort first word: got %b/%02h expected 1/30", o_valid, o_data);
    end
    tick();
    i_abort = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h31) begin
      errors++;
      $display("FAIL abort second word: got %b/%02h expected 1/31", o_valid, o_data);
    end
    tick();
    i_abort = 1'b0;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("after_abort");
      tick();
    end
    run_check(2'd0, 8'h30, 8'd4, 8'd1, 100, "abort_restart");
  endtask

  task automatic test_reset_mid_gap();
    i_mode = 2'd0; i_seed = 8'h10; i_burst_len = 8'd2; i_gap_len = 8'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_gap state: busy/valid got %b%b expected 10", o_busy, o_valid);
    end
    #2 res_n = 1'b0;
    #1;
    checks++;
    if (o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_gap data: got %02h expected 00", o_data);
    end
    check_idle("reset_mid_gap");
    @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle("after_reset_mid_gap");
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [7:0] s, l, g;
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(3));
      s = 8'($urandom);
      l = ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      g = 8'($urandom_range(0, 3));
      run_check(m, s, l, g, int'($urandom_range(30, 100)), "random");
    end
  endtask

  initial begin
    res_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_mode = 2'd0; i_burst_len = 8'd0; i_gap_len = 8'd0; i_seed = 8'd0;
    test_reset();
    run_check(2'd0, 8'hFE, 8'd3, 8'd2, 100, "incr_gap");
    run_check(2'd1, 8'h5A, 8'd10, 8'd1, -1, "walk_toggle");
    run_check(2'd2, 8'hA5, 8'd0, 8'd0, 100, "const_256");
    run_check(2'd3, 8'h00, 8'd5, 8'd0, 100, "mode3_seed0");
    run_check(2'd3, 8'h9C, 8'd7, 8'd3, 60, "mode3_seed");
    test_abort();
    test_reset_mid_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
